// File: rtl/discrete_mapper_pkg.sv
// discrete_mapper_pkg: mapper numbers, mirroring codes, write FSM encodings and mode decode.
// Build option: DISCRETE_MAPPER_BUSCONFLICT_EN adds the S_RD state.
package discrete_mapper_pkg;
  localparam logic [7:0] MAP_NROM = 8'd0, MAP_UXROM = 8'd2, MAP_CNROM = 8'd3, MAP_AXROM = 8'd7;
  localparam logic [2:0] MIRRHOR = 3'd0, MIRRVER = 3'd1, MIRR4 = 3'd2, MIRRA = 3'd3, MIRRB = 3'd4;
  localparam logic [1:0] S_IDLE = 2'd0, S_ACK = 2'd1;
`ifdef DISCRETE_MAPPER_BUSCONFLICT_EN
  localparam logic [1:0] S_RD = 2'd2;
`endif
  typedef enum logic [1:0] {M_NROM, M_UXROM, M_CNROM, M_AXROM} mode_t;
  function automatic mode_t mode_of(input logic [7:0] mapnum);
    return mapnum == MAP_UXROM ? M_UXROM : mapnum == MAP_CNROM ? M_CNROM :
           mapnum == MAP_AXROM ? M_AXROM : M_NROM;
  endfunction
endpackage

// File: rtl/discrete_mapper_if.sv
// discrete_mapper_if: CPU, PPU, PRG ROM, CHR ROM and CHR RAM buses of the mapper.
// slave: mapper side; master: system side.
interface discrete_mapper_if #(parameter int ADDR_W = 21);
  logic [15:0] memaddr;
  logic [7:0] memwdata, prgrdata;
  logic memwr, prgreq, prgack;
  logic [13:0] vmemaddr;
  logic [7:0] vmemwdata, chrrdata;
  logic vmemwr, chrreq, chrack;
  logic [ADDR_W-1:0] promaddr, cromaddr;
  logic [7:0] promdata, cromdata;
  logic promreq, promack, cromreq, cromack;
  logic [12:0] chrramaddr;
  logic [7:0] chrramrdata, chrramwdata;
  logic chramwr, chrramreq, chrramack;
  modport slave (
    input memaddr, memwdata, memwr, prgreq, vmemaddr, vmemwdata, vmemwr, chrreq,
          promdata, promack, cromdata, cromack, chrramrdata, chrramack,
    output prgrdata, prgack, chrrdata, chrack, promaddr, promreq, cromaddr, cromreq,
           chrramaddr, chrramwdata, chramwr, chrramreq
  );
  modport master (
    output memaddr, memwdata, memwr, prgreq, vmemaddr, vmemwdata, vmemwr, chrreq,
           promdata, promack, cromdata, cromack, chrramrdata, chrramack,
    input prgrdata, prgack, chrrdata, chrack, promaddr, promreq, cromaddr, cromreq,
          chrramaddr, chrramwdata, chramwr, chrramreq
  );
endinterface

// File: rtl/discrete_mapper_bankreg.sv
// discrete_mapper_bankreg: CPU write FSM and the bank register.
// Ports: req/wr/regsel/wdata from the CPU bus; bankreg, idle, wack (write ack), rdreq (bus-conflict ROM read).
// Build option: DISCRETE_MAPPER_BUSCONFLICT_EN adds conflict/promack/promdata and the S_RD read.
module discrete_mapper_bankreg
  import discrete_mapper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       wr,
  input  logic       regsel,
  input  logic [7:0] wdata,
`ifdef DISCRETE_MAPPER_BUSCONFLICT_EN
  input  logic       conflict,
  input  logic       promack,
  input  logic [7:0] promdata,
`endif
  output logic [7:0] bankreg,
  output logic       idle,
  output logic       wack,
  output logic       rdreq
);
  logic [1:0] state;
  logic go;
  assign idle = state == S_IDLE;
  assign go = idle & req & wr;
`ifdef DISCRETE_MAPPER_BUSCONFLICT_EN
  assign rdreq = state == S_RD;
  assign wack = state == S_ACK | (rdreq & promack);
  // register writes on conflicting mappers latch the AND of CPU data and ROM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bankreg <= '0;
    end else if (go) begin
      state <= regsel & conflict ? S_RD : S_ACK;
      if (regsel & ~conflict) bankreg <= wdata;
    end else if (rdreq & promack) begin
      state <= S_IDLE;
      bankreg <= wdata & promdata;
    end else if (state == S_ACK) begin
      state <= S_IDLE;
    end
  end
`else
  assign rdreq = 1'b0;
  assign wack = state == S_ACK;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bankreg <= '0;
    end else if (go) begin
      state <= S_ACK;
      if (regsel) bankreg <= wdata;
    end else if (state == S_ACK) begin
      state <= S_IDLE;
    end
  end
`endif
endmodule

// File: rtl/discrete_mapper.sv
// discrete_mapper: NROM/UxROM/CNROM/AxROM PRG/CHR bank address generation and mirroring.
// Ports: clk, rst (async, active high), header (iNES), mirr (mirroring code), bus (discrete_mapper_if.slave).
// Build option: DISCRETE_MAPPER_BUSCONFLICT_EN emulates bus conflicts on UxROM/CNROM/AxROM register writes.
module discrete_mapper
  import discrete_mapper_pkg::*;
#(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 2,
  parameter int ADDR_W = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  header,
  output logic [2:0]    mirr,
  discrete_mapper_if.slave bus
);
  logic [7:0] prgcnt, chrcnt, bankreg;
  logic chrram, idle, wack, rdreq, rd, unused;
  mode_t mode;
  logic [ADDR_W-1:0] prgmask, nromaddr, uxaddr, axaddr;
  logic [PRG_BANK_W-1:0] uxbank;
  logic [CHR_BANK_W-1:0] chrbank;
  assign mode = mode_of({header[63:60], header[55:52]});
  assign prgcnt = header[39:32];
  assign chrcnt = header[47:40];
  assign chrram = chrcnt == 8'd0;
  // counts are powers of two, so size-1 is an address mask; 128 banks wraps to all ones
  assign prgmask = ADDR_W'({prgcnt, 14'b0}) - ADDR_W'(1);
  assign nromaddr = ADDR_W'(bus.memaddr[14:0]) & prgmask;
  assign uxbank = bus.memaddr[14] ? PRG_BANK_W'(prgcnt - 8'd1)
                                  : bankreg[PRG_BANK_W-1:0] & PRG_BANK_W'(prgcnt - 8'd1);
  assign uxaddr = ADDR_W'({uxbank, bus.memaddr[13:0]});
  assign axaddr = ADDR_W'({bankreg[2:0], bus.memaddr[14:0]}) & prgmask;
  assign chrbank = mode == M_CNROM ? bankreg[CHR_BANK_W-1:0] & CHR_BANK_W'(chrcnt - 8'd1) : '0;
  assign rd = bus.prgreq & ~bus.memwr;
  discrete_mapper_bankreg u_bankreg (
    .clk,
    .rst,
    .req(bus.prgreq),
    .wr(bus.memwr),
    .regsel(bus.memaddr[15]),
    .wdata(bus.memwdata),
`ifdef DISCRETE_MAPPER_BUSCONFLICT_EN
    .conflict(mode != M_NROM),
    .promack(bus.promack),
    .promdata(bus.promdata),
`endif
    .bankreg,
    .idle,
    .wack,
    .rdreq
  );
  assign bus.promaddr = mode == M_UXROM ? uxaddr : mode == M_AXROM ? axaddr : nromaddr;
  assign bus.promreq = (rd & idle) | rdreq;
  assign bus.prgack = wack | (rd & idle & bus.promack);
  assign bus.prgrdata = bus.promdata;
  assign bus.cromreq = ~chrram & bus.chrreq;
  assign bus.cromaddr = chrram ? '0 : ADDR_W'({chrbank, bus.vmemaddr[12:0]});
  assign bus.chrramreq = chrram & bus.chrreq;
  assign bus.chrramaddr = chrram ? bus.vmemaddr[12:0] : '0;
  assign bus.chrramwdata = chrram ? bus.vmemwdata : '0;
  assign bus.chramwr = chrram & bus.vmemwr;
  assign bus.chrack = chrram ? bus.chrramack : bus.cromack;
  assign bus.chrrdata = chrram ? bus.chrramrdata : bus.cromdata;
  assign mirr = mode == M_AXROM ? (bankreg[4] ? MIRRB : MIRRA)
              : header[51] ? MIRR4 : header[48] ? MIRRVER : MIRRHOR;
  assign unused = ^{header[127:64], header[59:56], header[50:49], header[31:0],
                    bankreg[7:5], bus.vmemaddr[13]};
endmodule

// File: doc/discrete_mapper.md
Name: discrete_mapper

Overview:
- Parametrised successor to the fixed-bank cartridge mapper. Serves iNES mappers 0 (NROM), 2 (UxROM), 3 (CNROM) and 7 (AxROM) from one block, selected at runtime from the header mapper number.
- Adds a CPU-writable bank register, PRG/CHR bank address generation, and single-screen mirroring.
- Sits between the CPU/PPU memory ports and the PRG/CHR ROM and CHR RAM arbiters.

Parameters:
- PRG_BANK_W, 4: width of the 16 KiB PRG bank select (max 2^4 × 16 KiB).
- CHR_BANK_W, 2: width of the 8 KiB CHR bank select.
- ADDR_W, 21: width of promaddr/cromaddr.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- memaddr  in  16  CPU address
- memwdata  in  8  CPU write data
- memwr  in  1  CPU write qualifier
- prgreq  in  1  CPU cartridge access request
- prgrdata  out  8  CPU read data
- prgack  out  1  CPU access done
- vmemaddr  in  14  PPU address
- vmemwdata  in  8  PPU write data
- vmemwr  in  1  PPU write qualifier
- chrreq  in  1  PPU request
- chrrdata  out  8  PPU read data
- chrack  out  1  PPU access done
- promaddr/promdata/promreq/promack  out/in/out/in  ADDR_W/8/1/1  PRG ROM port
- cromaddr/cromdata/cromreq/cromack  out/in/out/in  ADDR_W/8/1/1  CHR ROM port
- chrramaddr/chrramrdata/chrramwdata/chramwr/chrramreq/chrramack  out/in/out/out/out/in  13/8/8/1/1/1  CHR RAM port
- header  in  128  iNES header
- mirr  out  3  mirroring code (dat.vh constants)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Mapper decode: mapnum = {header[63:60], header[55:52]}. Values 0/2/3/7 select the mode; any other value runs as NROM.
- prgcnt = header[39:32]; chrcnt = header[47:40]; chrram = (chrcnt == 0). Counts are powers of two.
- Bank register bankreg (8 bits): reset 0. Written only by an accepted register write.
- Register write accepted when prgreq & memwr & memaddr[15] in state IDLE.
- PRG reads (prgreq & ~memwr), combinational passthrough as before:
  - promreq = prgreq, prgack = promack, prgrdata = promdata.
  - NROM: promaddr = memaddr[14:0] & (prgcnt*16K − 1); this mirrors 16 KiB images.
  - UxROM: bank = memaddr[14] ? prgcnt−1 : bankreg[PRG_BANK_W−1:0] & (prgcnt−1); promaddr = {bank, memaddr[13:0]} zero-extended.
  - AxROM: promaddr = {bankreg[2:0], memaddr[14:0]} masked to the PRG size.
  - CNROM: same as NROM.
- CHR:
  - CNROM: cromaddr = {bankreg[CHR_BANK_W−1:0] & (chrcnt−1), vmemaddr[12:0]}. Other modes: bank 0.
  - chrram routes chrreq/chrack/chrrdata to CHR RAM and the ROM side to 0; otherwise the reverse.
  - CHR RAM writes use vmemwdata/vmemwr (not the CPU bus); ROM ignores writes.
- Write FSM, states IDLE and ACK:
  - IDLE → ACK on accepted write; bankreg ← memwdata at that edge.
  - ACK: prgack = 1 for exactly one cycle, promreq = 0, then → IDLE.
  - Writes are never forwarded to PRG ROM; prgack for writes comes from the FSM only.
- Mirroring:
  - NROM/UxROM/CNROM: header[51] → `MIRR4, else header[48] → `MIRRVER, else `MIRRHOR.
  - AxROM: bankreg[4] ? `MIRRB : `MIRRA (single screen).
- Reset values: bankreg 0, FSM IDLE, FSM prgack 0. mirr follows the header combinationally.
- Reset mid-operation: FSM returns to IDLE, any pending ack is dropped, bankreg = 0.
- Write while the FSM is not in IDLE: held off; the requester keeps prgreq high until prgack.
- Writes to memaddr < $8000: ignored, with prgack still pulsed in ACK.

Optional Feature:
- Macro: DISCRETE_MAPPER_BUSCONFLICT_EN.
- When defined, bus conflicts are emulated for UxROM/CNROM/AxROM. An accepted write goes IDLE → RD and drives promreq = 1 with the read promaddr of memaddr. On promack: bankreg ← memwdata & promdata, prgack = 1 that cycle, → IDLE.
- Reset during RD: promreq drops immediately.
- NROM writes use the ACK path.
- When undefined: the RD state does not exist and the behaviour is as above.

Decomposition:
- dat.vh: mapper number constants (MAP_NROM=0, MAP_UXROM=2, MAP_CNROM=3, MAP_AXROM=7); `MIRRA/`MIRRB single-screen codes, added alongside `MIRRHOR/`MIRRVER/`MIRR4; FSM state encodings.
- Natural sub-module: mapper_bankreg, holding the write FSM plus bankreg (and the bus-conflict read when the macro is defined). Address generation stays in the top module.

Test Plan:
- UxROM, prgcnt=8: write $05 to $C000, then read $8123 → promaddr=0x14123; read $C123 → promaddr=0x1C123; prgack pulses one cycle after the write.
- NROM, prgcnt=1: read $C010 → promaddr=0x0010; write $FF to $8000 → promreq stays 0, bankreg has no effect.
- CNROM, chrcnt=4: write $03, then PPU read $0ABC → cromaddr=0x6ABC, chrramreq=0. With chrcnt=0: chrramreq follows chrreq, vmemwr → chramwr.
- AxROM: write $13 → PRG reads at $8000 map to 0x18000; mirr=`MIRRB. Write $00 → mirr=`MIRRA.
- BUSCONFLICT_EN, UxROM: write $0F while promdata=$06 → bankreg=$06 after promack. Assert rst during RD → promreq=0 next sample, bankreg=0.
- Unknown mapper 4 with header[48]=1: behaves as NROM, mirr=`MIRRVER.
